// File: rtl/fixed_mul_seq_if.sv
// Handshake and operand/result bundle for the sequential fixed-point multiplier.
// The master issues start with operands; the slave reports status and the product.
interface fixed_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic             valid_o;
    logic             ovf_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] val_o;

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, valid_o, ovf_o, val_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, valid_o, ovf_o, val_o
    );
endinterface

// File: rtl/fixed_mul_seq.sv
// Iterative signed fixed-point multiplier: one multiplier bit per cycle on magnitudes,
// then scale, saturate and re-apply the sign. Fixed latency of WIDTH+2 cycles.
module fixed_mul_seq #(
    parameter int WIDTH = 32,
    parameter int FBITS = 14
) (
    input logic            clk,
    input logic            reset_i,
    fixed_mul_seq_if.slave bus
);
    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [AW-1:0]    MAX_POS_MAG = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [AW-1:0]    MAX_NEG_MAG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_POS     = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG     = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FINAL
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             step;
    logic             finish;

    logic [AW-1:0]    mcand;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             sign;

    logic [AW-1:0]    mag;
    logic [WIDTH-1:0] mag_w;
    logic [WIDTH-1:0] res;
    logic             res_ovf;

    logic [WIDTH-1:0] val_q;
    logic             ovf_q;
    logic             done_q;
    logic             valid_q;

    // Most negative input maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start_i) begin
                    load       = 1'b1;
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_next = S_FINAL;
            end
            S_FINAL: begin
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Scale back to FBITS, truncating the magnitude (i.e. toward zero), then saturate.
    always_comb begin
        mag     = acc >> FBITS;
        mag_w   = mag[WIDTH-1:0];
        res_ovf = sign ? (mag > MAX_NEG_MAG) : (mag > MAX_POS_MAG);
        if (res_ovf) res = sign ? SAT_NEG : SAT_POS;
        else         res = sign ? (~mag_w + 1'b1) : mag_w;
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            val_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                mcand   <= {{WIDTH{1'b0}}, abs_val(bus.a_i)};
                mplier  <= abs_val(bus.b_i);
                acc     <= '0;
                cnt     <= '0;
                sign    <= bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1];
                valid_q <= 1'b0;
            end
            if (step) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            if (finish) begin
                val_q   <= res;
                ovf_q   <= res_ovf;
                valid_q <= 1'b1;
            end
        end
    end

    assign bus.busy_o  = (state != S_IDLE);
    assign bus.done_o  = done_q;
    assign bus.valid_o = valid_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.val_o   = val_q;
endmodule

// File: tb/tb_fixed_mul_seq.sv
// Directed-vector bench for fixed_mul_seq (WIDTH=32, FBITS=14): latency, sign,
// saturation, truncation, handshake corner cases and mid-operation reset.
module tb_fixed_mul_seq;
    localparam int WIDTH = 32;
    localparam int FBITS = 14;

    logic clk;
    logic reset_i;
    int   n_checks;
    int   n_pass;

    fixed_mul_seq_if #(.WIDTH(WIDTH)) ifc ();

    fixed_mul_seq #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Drives a one-cycle start and waits (bounded) for done. Returns the number of
    // posedges from the start edge (inclusive) to done, or -1 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inject,
                          output int lat, output int busy_n);
        ifc.a_i     = a;
        ifc.b_i     = b;
        ifc.start_i = 1'b1;
        lat         = -1;
        busy_n      = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            ifc.start_i = 1'b0;
            if (i == 1) check("valid_drop", {31'd0, ifc.valid_o}, 32'd0);
            if (i == 2) begin
                ifc.a_i = ~a;
                ifc.b_i = ~b;
            end
            if (inject && (i == 5 || i == 20)) begin
                ifc.a_i     = 32'h7FFF_FFFF;
                ifc.b_i     = 32'h7FFF_FFFF;
                ifc.start_i = 1'b1;
            end
            if (ifc.busy_o) busy_n++;
            if (ifc.done_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input logic [31:0] exp_val, input logic exp_ovf);
        int lat;
        int busy_n;
        run_op(a, b, inject, lat, busy_n);
        check({tag, "_lat"}, lat, 32'd34);
        check({tag, "_busy"}, busy_n, 32'd33);
        check({tag, "_val"}, ifc.val_o, exp_val);
        check({tag, "_ovf"}, {31'd0, ifc.ovf_o}, {31'd0, exp_ovf});
        check({tag, "_valid"}, {31'd0, ifc.valid_o}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, ifc.busy_o}, 32'd0);
    endtask

    initial begin
        int lat;
        int busy_n;
        int done_seen;
        n_checks    = 0;
        n_pass      = 0;
        reset_i     = 1'b0;
        ifc.start_i = 1'b0;
        ifc.a_i     = '0;
        ifc.b_i     = '0;

        #2;
        check("rst_busy",  {31'd0, ifc.busy_o},  32'd0);
        check("rst_done",  {31'd0, ifc.done_o},  32'd0);
        check("rst_valid", {31'd0, ifc.valid_o}, 32'd0);
        check("rst_ovf",   {31'd0, ifc.ovf_o},   32'd0);
        check("rst_val",   ifc.val_o,            32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);

        do_mul("mul_2x3", 32'h0000_8000, 32'h0000_C000, 1'b0, 32'h0001_8000, 1'b0);
        @(posedge clk);
        #1;
        check("done_pulse", {31'd0, ifc.done_o},  32'd0);
        check("valid_hold", {31'd0, ifc.valid_o}, 32'd1);
        check("val_hold",   ifc.val_o,            32'h0001_8000);
        @(negedge clk);

        do_mul("neg_x_pos", 32'hFFFF_A000, 32'h0000_8000, 1'b0, 32'hFFFF_4000, 1'b0);
        @(negedge clk);
        do_mul("neg_x_neg", 32'hFFFF_A000, 32'hFFFF_8000, 1'b0, 32'h0000_C000, 1'b0);
        @(negedge clk);
        do_mul("sat_pos",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1);
        @(negedge clk);
        do_mul("sat_neg",   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h8000_0000, 1'b1);
        @(negedge clk);

        // Mid-operation reset: outputs drop at once and no done ever appears.
        ifc.a_i     = 32'h0000_8000;
        ifc.b_i     = 32'h0000_C000;
        ifc.start_i = 1'b1;
        done_seen   = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            ifc.start_i = 1'b0;
        end
        reset_i = 1'b0;
        #1;
        check("abort_busy",  {31'd0, ifc.busy_o},  32'd0);
        check("abort_valid", {31'd0, ifc.valid_o}, 32'd0);
        check("abort_ovf",   {31'd0, ifc.ovf_o},   32'd0);
        check("abort_val",   ifc.val_o,            32'd0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (ifc.done_o) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        do_mul("post_rst", 32'h0000_8000, 32'h0000_C000, 1'b0, 32'h0001_8000, 1'b0);
        @(negedge clk);

        do_mul("trunc_pos", 32'h0000_0001, 32'h0000_2000, 1'b0, 32'h0000_0000, 1'b0);
        @(negedge clk);
        do_mul("trunc_neg", 32'hFFFF_FFFF, 32'h0000_2000, 1'b0, 32'h0000_0000, 1'b0);
        @(negedge clk);
        do_mul("min_x_one", 32'h8000_0000, 32'h0000_4000, 1'b0, 32'h8000_0000, 1'b0);
        @(negedge clk);
        do_mul("min_x_m1",  32'h8000_0000, 32'hFFFF_C000, 1'b0, 32'h7FFF_FFFF, 1'b1);
        @(negedge clk);

        // Starts while busy are ignored; a start in the done cycle is accepted.
        do_mul("ignore_start", 32'h0000_8000, 32'h0000_C000, 1'b1, 32'h0001_8000, 1'b0);
        do_mul("b2b",          32'hFFFF_A000, 32'h0000_8000, 1'b0, 32'hFFFF_4000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
